bcm_framebuffer: RTL and testbench

//  Pixel source feeding the HUB75 led_driver in place of a procedural painter: stores a
//  64x64 RGB image and returns one bit-plane bit per channel for the driver's (x, y) scan.
//  Two read ports (top/bottom half rows) share one write port from a host/loader stage.

---
 rtl/bcm_framebuffer.sv | 164 ++++++++++++++++
 tb/tb_bcm_framebuffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcm_framebuffer.sv
// bcm_framebuffer: 64x64 RGB bit-plane frame store for the HUB75 led_driver.
// Two registered read ports (top/bottom half rows) and one write port with a
// valid/ready handshake. A hardware clear engine zeroes the write page.
// Optional feature macro: BCM_DOUBLE_BUFFER_EN (two pages, swap at frame_start).
module bcm_framebuffer #(
  parameter int BPC = 3,
  parameter int XW  = 6,
  parameter int YW  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       plane,
  input  logic             frame_start,
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y0,
  input  logic [YW-1:0]    y1,
  output logic [2:0]       rgb0,
  output logic [2:0]       rgb1,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [XW-1:0]    wr_x,
  input  logic [YW-1:0]    wr_y,
  input  logic [3*BPC-1:0] wr_rgb,
  input  logic             clear,
  output logic             busy,
  input  logic             swap_req,
  output logic             swap_done,
  output logic             dbg_state
);

  localparam int AW = XW + YW;
  localparam int W  = 3 * BPC;

  // Handshake: a write transfers on a rising clk edge where wr_valid and
  // wr_ready are both high; wr_ready is high only while the clear engine is
  // idle, and a request seen while wr_ready is low is simply not taken (the
  // host keeps wr_valid and its payload stable until the transfer happens).

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          mem_we;
  logic [AW-1:0] mem_wa_lin;
  logic [W-1:0]  mem_wd;

`ifdef BCM_DOUBLE_BUFFER_EN
  localparam int MAW = AW + 1;
  logic display_q;
  logic swap_pending_q;
  logic swap_done_q;
`else
  localparam int MAW = AW;
`endif

  logic [MAW-1:0] rd_addr0, rd_addr1, wr_addr;
  logic [W-1:0]   mem [0:(2**MAW)-1];

  // Extract the {R,G,B} bits of one brightness plane; planes past BPC read 0.
  function automatic logic [2:0] plane_bits(input logic [W-1:0] w, input logic [1:0] p);
    int pi;
    pi = int'(p);
    plane_bits = 3'b000;
    if (pi < BPC) plane_bits = {w[2*BPC + pi], w[BPC + pi], w[pi]};
  endfunction

  // Clear engine state and address counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, handshake outputs and write-port mux (clear has priority).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ready   = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_wa_lin = {wr_y, wr_x};
    mem_wd     = wr_rgb;
    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        mem_we   = wr_valid;
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy       = 1'b1;
        mem_we     = 1'b1;
        mem_wa_lin = cnt_q;
        mem_wd     = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

`ifdef BCM_DOUBLE_BUFFER_EN
  // Reads use the display page, writes and clears use the other page.
  assign rd_addr0  = {display_q, y0, x};
  assign rd_addr1  = {display_q, y1, x};
  assign wr_addr   = {~display_q, mem_wa_lin};
  assign swap_done = swap_done_q;

  // Page swap: latch requests, toggle at frame_start once the clear engine is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      display_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      swap_done_q <= 1'b0;
      if (frame_start && (swap_pending_q || swap_req) && (state_q == IDLE)) begin
        display_q      <= ~display_q;
        swap_pending_q <= 1'b0;
        swap_done_q    <= 1'b1;
      end else if (swap_req) begin
        swap_pending_q <= 1'b1;
      end
    end
  end
`else
  // Single page: reads and writes share it, swapping never happens.
  logic unused_swap_inputs;
  assign rd_addr0           = {y0, x};
  assign rd_addr1           = {y1, x};
  assign wr_addr            = mem_wa_lin;
  assign swap_done          = 1'b0;
  assign unused_swap_inputs = ^{frame_start, swap_req};
`endif

  // Pixel store write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= mem_wd;
  end

  // Registered read ports; a same-cycle write is seen on the following read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb0 <= 3'b000;
      rgb1 <= 3'b000;
    end else begin
      rgb0 <= plane_bits(mem[rd_addr0], plane);
      rgb1 <= plane_bits(mem[rd_addr1], plane);
    end
  end

endmodule

// File: tb/tb_bcm_framebuffer.sv
// tb_bcm_framebuffer: directed plus randomized checks of bcm_framebuffer
// against a page/array reference model. Honors BCM_DOUBLE_BUFFER_EN.
module tb_bcm_framebuffer;

`ifdef BCM_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  // Clock / reset and DUT signals
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] plane = '0;
  logic       frame_start = 1'b0;
  logic [5:0] x = '0, y0 = '0, y1 = '0;
  logic [2:0] rgb0, rgb1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [5:0] wr_x = '0, wr_y = '0;
  logic [8:0] wr_rgb = '0;
  logic       clear = 1'b0;
  logic       busy;
  logic       swap_req = 1'b0;
  logic       swap_done;
  logic       dbg_state;

  always #5 clk = ~clk;

  bcm_framebuffer dut (
    .clk(clk), .reset_n(reset_n), .plane(plane), .frame_start(frame_start),
    .x(x), .y0(y0), .y1(y1), .rgb0(rgb0), .rgb1(rgb1),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_rgb(wr_rgb), .clear(clear), .busy(busy), .swap_req(swap_req),
    .swap_done(swap_done), .dbg_state(dbg_state)
  );

  // Reference model: page contents, displayed page and pending swap
  logic [8:0] mdl [2][4096];
  int         disp = 0;
  bit         pend = 1'b0;
  int         n_assert = 0;
  int         n_fail = 0;

  // One comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plane p bit of each colour channel, from plain arithmetic on the pixel word
  function automatic logic [2:0] pix_bits(input logic [8:0] w, input int p);
    int r, g, b;
    r = int'(w) / 64;
    g = (int'(w) / 8) % 8;
    b = int'(w) % 8;
    if (p >= 3) return 3'b000;
    return {1'(r >> p), 1'(g >> p), 1'(b >> p)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; clear = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
  endtask

  // Advance one clock with the currently driven inputs and check against the model
  task automatic cycle();
    logic [2:0] e0, e1;
    bit         esw;
    int         wp;
    e0 = pix_bits(mdl[disp][{y0, x}], int'(plane));
    e1 = pix_bits(mdl[disp][{y1, x}], int'(plane));
    wp = DB ? 1 - disp : disp;
    if (wr_valid) mdl[wp][{wr_y, wr_x}] = wr_rgb;
    esw = 1'b0;
    if (DB) begin
      if (frame_start && (pend || swap_req)) begin
        disp = 1 - disp; pend = 1'b0; esw = 1'b1;
      end else if (swap_req) begin
        pend = 1'b1;
      end
    end
    step();
    chk("rgb0", rgb0, e0);
    chk("rgb1", rgb1, e1);
    chk("swap_done", swap_done, esw);
    chk("wr_ready_idle", wr_ready, 1);
  endtask

  // Run a full clear, optionally with a write accepted in the same cycle
  task automatic clear_full(input bit with_write);
    int n;
    bit ready_seen;
    clear = 1'b1; wr_valid = with_write; wr_x = 6'd10; wr_y = 6'd10; wr_rgb = 9'h1FF;
    step();
    clear = 1'b0; wr_valid = 1'b0;
    n = 0; ready_seen = 1'b0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      if (wr_ready !== 1'b0) ready_seen = 1'b1;
      step();
    end
    chk("clear_busy_cycles", n, 4096);
    chk("clear_wr_ready_low", ready_seen, 0);
    chk("busy_after_clear", busy, 0);
    chk("wr_ready_after_clear", wr_ready, 1);
    for (int i = 0; i < 4096; i++) mdl[DB ? 1 - disp : disp][i] = 9'h000;
  endtask

`ifdef BCM_DOUBLE_BUFFER_EN
  // Swap pages without read checks (used while one page is still uninitialised)
  task automatic swap_raw();
    swap_req = 1'b1; frame_start = 1'b1;
    step();
    swap_req = 1'b0; frame_start = 1'b0;
    chk("swap_raw_done", swap_done, 1);
    disp = 1 - disp;
    step();
    chk("swap_raw_done_low", swap_done, 0);
  endtask
`endif

  initial begin
    // Reset state
    #2 reset_n = 1'b0;
    step(); step();
    chk("rst_rgb0", rgb0, 0);
    chk("rst_rgb1", rgb1, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    step();

    // Initialise memory
    clear_full(1'b0);
`ifdef BCM_DOUBLE_BUFFER_EN
    swap_raw();
    clear_full(1'b0);
`endif

    // Pixel (3,5) bit planes
    wr_valid = 1'b1; wr_x = 6'd3; wr_y = 6'd5; wr_rgb = 9'b111_010_001;
    cycle();
    wr_valid = 1'b0; swap_req = 1'b1; frame_start = 1'b1;
    cycle();
    idle_inputs();
    x = 6'd3; y0 = 6'd5; y1 = 6'd37;
    plane = 2'd0; cycle(); chk("plane0", rgb0, 3'b101);
    plane = 2'd1; cycle(); chk("plane1", rgb0, 3'b110);
    plane = 2'd2; cycle(); chk("plane2", rgb0, 3'b100);
    plane = 2'd3; cycle(); chk("plane3", rgb0, 3'b000);

    // Read/write same address in the same cycle
    x = 6'd0; y0 = 6'd0; y1 = 6'd32; plane = 2'd0;
    wr_valid = 1'b1; wr_x = 6'd0; wr_y = 6'd0; wr_rgb = 9'h1FF;
    cycle();
    wr_rgb = 9'h000;
    cycle();
`ifndef BCM_DOUBLE_BUFFER_EN
    chk("rw_same_old", rgb0, 3'b111);
`endif
    wr_valid = 1'b0;
    cycle();
`ifndef BCM_DOUBLE_BUFFER_EN
    chk("rw_same_new", rgb0, 3'b000);
`endif

    // Randomized traffic in a small window to get frequent hits
    for (int i = 0; i < 400; i++) begin
      wr_valid    = 1'($urandom_range(0, 1));
      wr_x        = 6'($urandom_range(8, 15));
      wr_y        = 6'($urandom_range(8, 15));
      wr_rgb      = 9'($urandom_range(0, 511));
      x           = 6'($urandom_range(8, 15));
      y0          = 6'($urandom_range(8, 15));
      y1          = 6'($urandom_range(8, 15));
      plane       = 2'($urandom_range(0, 3));
      swap_req    = ($urandom_range(0, 15) == 0);
      frame_start = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle_inputs();

    // Back-page write followed by a deferred swap
    x = 6'd40; y0 = 6'd40; y1 = 6'd41; plane = 2'd0;
    wr_valid = 1'b1; wr_x = 6'd40; wr_y = 6'd40; wr_rgb = 9'h0AA;
    cycle();
    wr_valid = 1'b0; swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
`ifdef BCM_DOUBLE_BUFFER_EN
    chk("no_swap_before_fs", rgb0, 3'b000);
`endif
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    cycle();
    chk("after_swap_rgb0", rgb0, 3'b010);

    // Reset asserted mid-traffic
    wr_valid = 1'b1; wr_x = 6'd9; wr_y = 6'd9; wr_rgb = 9'($urandom_range(0, 511));
    cycle();
    #2 reset_n = 1'b0; wr_valid = 1'b0;
    #1;
    chk("mid_rst_rgb0", rgb0, 0);
    chk("mid_rst_rgb1", rgb1, 0);
    chk("mid_rst_wr_ready", wr_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_swap_done", swap_done, 0);
    step();
    reset_n = 1'b1;
    disp = 0; pend = 1'b0;
    step();

    // Clear with a same-cycle write, then every pixel reads zero
    clear_full(1'b1);
`ifdef BCM_DOUBLE_BUFFER_EN
    x = 6'd0; y0 = 6'd0; y1 = 6'd32;
    swap_req = 1'b1; frame_start = 1'b1;
    cycle();
    idle_inputs();
`endif
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 64; c++) begin
        x = 6'(c); y0 = 6'(r); y1 = 6'(r + 32); plane = 2'(c % 3);
        step();
        chk("cleared_rgb0", rgb0, 0);
        chk("cleared_rgb1", rgb1, 0);
      end
    end

    // Reset during clear, then a fresh full clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (100) step();
    chk("clear_running", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_clear_busy", busy, 0);
    chk("rst_clear_wr_ready", wr_ready, 1);
    chk("rst_clear_state", dbg_state, 0);
    step();
    reset_n = 1'b1;
    disp = 0; pend = 1'b0;
    step();
    clear_full(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
